mips_id_stage: RTL and testbench

- Instruction-decode / register-fetch stage of the two-phase MIPS32 pipeline.
- Consumes the IF/ID latch (instruction word and next-PC) and owns the 32x32 register bank; the WB stage writes the bank through a dedicated port.
- Produces the ID/EX latch: IR, NPC, A, B, sign-extended Imm and instruction type.
- Detects load-use hazards and issues bubbles; honours branch flush, the global halt, and a post-HLT fetch squash.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mips_regfile.sv | 47 ++++
 rtl/mips_id_stage.sv | 150 +++++++++++++++
 tb/tb_mips_id_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS32 decode stage: opcode values, instruction
// class codes carried down the pipe in id_ex_type, and the bit positions of
// the instruction fields. Also provides decodeType(), the opcode-to-class map.
// ---------------------------------------------------------------------------
package mips_pkg;

  // Opcodes (ir[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Instruction classes
  localparam logic [2:0] TYPE_RR_ALU = 3'b000;
  localparam logic [2:0] TYPE_RM_ALU = 3'b001;
  localparam logic [2:0] TYPE_LOAD   = 3'b010;
  localparam logic [2:0] TYPE_STORE  = 3'b011;
  localparam logic [2:0] TYPE_BRANCH = 3'b100;
  localparam logic [2:0] TYPE_HALT   = 3'b101;
  localparam logic [2:0] TYPE_NOP    = 3'b110;

  // Instruction field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

  // Map an opcode onto its instruction class; anything unrecognised is NOP.
  function automatic logic [2:0] decodeType(input logic [5:0] opcode);
    logic [2:0] cls;
    cls = TYPE_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = TYPE_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     cls = TYPE_RM_ALU;
      OP_LW:                                         cls = TYPE_LOAD;
      OP_SW:                                         cls = TYPE_STORE;
      OP_BEQZ, OP_BNEQZ:                             cls = TYPE_BRANCH;
      OP_HLT:                                        cls = TYPE_HALT;
      default:                                       cls = TYPE_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// ---------------------------------------------------------------------------
// mips_regfile
// 2**REG_AW x DATA_W register bank with two combinational read ports and one
// synchronous write port. R0 always reads zero and ignores writes. A read of
// the register being written in the same cycle returns the incoming data, so
// the decode stage latches the freshly written value.
// Ports:
//   i_clk              write clock
//   i_we/i_waddr/i_wdata  write port
//   i_raddrA/o_rdataA  read port A (rs)
//   i_raddrB/o_rdataB  read port B (rt)
// The bank has no reset; its contents survive a pipeline reset.
// ---------------------------------------------------------------------------
module mips_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddrA,
  input  logic [REG_AW-1:0] i_raddrB,
  output logic [DATA_W-1:0] o_rdataA,
  output logic [DATA_W-1:0] o_rdataB
);

  logic [DATA_W-1:0] r_bank [2**REG_AW];

  // Writes to R0 are dropped here so entry 0 is never touched.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr != '0)) begin
      r_bank[i_waddr] <= i_wdata;
    end
  end

  // Read ports: R0 is hardwired to zero, then the write-through bypass,
  // then the stored value.
  assign o_rdataA = (i_raddrA == '0)                  ? '0 :
                    (i_we && (i_waddr == i_raddrA))   ? i_wdata :
                                                        r_bank[i_raddrA];

  assign o_rdataB = (i_raddrB == '0)                  ? '0 :
                    (i_we && (i_waddr == i_raddrB))   ? i_wdata :
                                                        r_bank[i_raddrB];

endmodule

// File: rtl/mips_id_stage.sv
// ---------------------------------------------------------------------------
// mips_id_stage
// Instruction decode / register fetch stage of the two-phase MIPS32 pipe.
// Decodes the IF/ID latch, reads rs/rt from the register bank (which WB
// writes through its own port) and produces the ID/EX latch. Detects
// load-use hazards and inserts a single bubble, kills the instruction on a
// branch flush, freezes entirely while halted, and bubbles everything once
// an HLT has been issued.
// Ports:
//   clk2, rst                  ID-phase clock, async active-high reset
//   if_id_ir/npc/valid         IF/ID latch
//   flush, halted              taken-branch kill, global freeze
//   wb_we/wb_addr/wb_data      register write port from WB
//   stall                      combinational; IF holds PC and IF/ID
//   halt_seen                  an HLT has entered ID/EX
//   id_ex_*                    ID/EX latch
// ---------------------------------------------------------------------------
module mips_id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_id_ir,
  input  logic [DATA_W-1:0] if_id_npc,
  input  logic              if_id_valid,
  input  logic              flush,
  input  logic              halted,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              halt_seen,
  output logic [DATA_W-1:0] id_ex_ir,
  output logic [DATA_W-1:0] id_ex_npc,
  output logic [DATA_W-1:0] id_ex_a,
  output logic [DATA_W-1:0] id_ex_b,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [2:0]        id_ex_type,
  output logic              id_ex_valid
);

  logic [5:0]        w_opcode;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [2:0]        w_type;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_regA;
  logic [DATA_W-1:0] w_regB;
  logic              w_regWe;
  logic [REG_AW-1:0] w_loadDest;
  logic              w_readsRs;
  logic              w_readsRt;
  logic              w_stall;

  logic [DATA_W-1:0] r_idExIr;
  logic [DATA_W-1:0] r_idExNpc;
  logic [DATA_W-1:0] r_idExA;
  logic [DATA_W-1:0] r_idExB;
  logic [DATA_W-1:0] r_idExImm;
  logic [2:0]        r_idExType;
  logic              r_idExValid;
  logic              r_haltSeen;

  // Field extraction and decode of the instruction sitting in IF/ID.
  assign w_opcode = if_id_ir[OPC_HI:OPC_LO];
  assign w_rs     = if_id_ir[RS_HI:RS_LO];
  assign w_rt     = if_id_ir[RT_HI:RT_LO];
  assign w_type   = decodeType(w_opcode);
  assign w_imm    = {{(DATA_W-IMM_W){if_id_ir[IMM_W-1]}}, if_id_ir[IMM_W-1:0]};

  // While halted even WB writes are frozen; gating here also keeps the
  // bypass consistent with what actually lands in the bank.
  assign w_regWe = wb_we && !halted;

  mips_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .i_clk    (clk2),
    .i_we     (w_regWe),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddrA (w_rs),
    .i_raddrB (w_rt),
    .o_rdataA (w_regA),
    .o_rdataB (w_regB)
  );

  // Load-use hazard: the load in ID/EX writes rt, and the instruction now in
  // ID reads that register before the load data exists. Everything except
  // HALT/NOP reads rs; only register-register ALU ops and stores read rt.
  // A load to R0 never hazards because R0 is constant.
  assign w_loadDest = r_idExIr[RT_HI:RT_LO];
  assign w_readsRs  = (w_type != TYPE_HALT) && (w_type != TYPE_NOP);
  assign w_readsRt  = (w_type == TYPE_RR_ALU) || (w_type == TYPE_STORE);
  assign w_stall    = r_idExValid && (r_idExType == TYPE_LOAD) &&
                      (w_loadDest != '0) &&
                      ((w_readsRs && (w_loadDest == w_rs)) ||
                       (w_readsRt && (w_loadDest == w_rt))) &&
                      if_id_valid && !flush && !halted;

  // ID/EX latch. Halted freezes everything. Flush, stall, a previously
  // issued HLT or an empty IF/ID all become bubbles: only valid/type change,
  // the data fields keep their previous contents. Otherwise the decoded
  // instruction is latched; unknown opcodes go through as invalid NOPs.
  // An HLT only sets halt_seen when it really issues.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_idExIr    <= '0;
      r_idExNpc   <= '0;
      r_idExA     <= '0;
      r_idExB     <= '0;
      r_idExImm   <= '0;
      r_idExType  <= TYPE_NOP;
      r_idExValid <= 1'b0;
      r_haltSeen  <= 1'b0;
    end else if (!halted) begin
      if (flush || w_stall || r_haltSeen || !if_id_valid) begin
        r_idExValid <= 1'b0;
        r_idExType  <= TYPE_NOP;
      end else begin
        r_idExIr    <= if_id_ir;
        r_idExNpc   <= if_id_npc;
        r_idExA     <= w_regA;
        r_idExB     <= w_regB;
        r_idExImm   <= w_imm;
        r_idExType  <= w_type;
        r_idExValid <= (w_type != TYPE_NOP);
        if (w_type == TYPE_HALT) begin
          r_haltSeen <= 1'b1;
        end
      end
    end
  end

  assign stall       = w_stall;
  assign halt_seen   = r_haltSeen;
  assign id_ex_ir    = r_idExIr;
  assign id_ex_npc   = r_idExNpc;
  assign id_ex_a     = r_idExA;
  assign id_ex_b     = r_idExB;
  assign id_ex_imm   = r_idExImm;
  assign id_ex_type  = r_idExType;
  assign id_ex_valid = r_idExValid;

endmodule

// File: tb/tb_mips_id_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_id_stage
// Self-checking bench for mips_id_stage: a directed vector table from reset,
// hand-written sequences for async reset, reset during a stall and the
// halted freeze, then randomized traffic compared against a behavioural
// model of the stage.
// ---------------------------------------------------------------------------
module tb_mips_id_stage;

  localparam logic [2:0] T_RR = 3'd0, T_RM = 3'd1, T_LD = 3'd2, T_ST = 3'd3,
                         T_BR = 3'd4, T_HT = 3'd5, T_NOP = 3'd6;

  logic        clk2 = 1'b0;
  logic        rst;
  logic [31:0] ifIdIr, ifIdNpc, wbData;
  logic        ifIdValid, flush, halted, wbWe;
  logic [4:0]  wbAddr;
  logic        stall, haltSeen, idExValid;
  logic [31:0] idExIr, idExNpc, idExA, idExB, idExImm;
  logic [2:0]  idExType;

  int total = 0;
  int bad   = 0;

  mips_id_stage dut (
    .clk2        (clk2),
    .rst         (rst),
    .if_id_ir    (ifIdIr),
    .if_id_npc   (ifIdNpc),
    .if_id_valid (ifIdValid),
    .flush       (flush),
    .halted      (halted),
    .wb_we       (wbWe),
    .wb_addr     (wbAddr),
    .wb_data     (wbData),
    .stall       (stall),
    .halt_seen   (haltSeen),
    .id_ex_ir    (idExIr),
    .id_ex_npc   (idExNpc),
    .id_ex_a     (idExA),
    .id_ex_b     (idExB),
    .id_ex_imm   (idExImm),
    .id_ex_type  (idExType),
    .id_ex_valid (idExValid)
  );

  always #5 clk2 = ~clk2;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] npc, input logic v,
                               input logic f, input logic h, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
    ifIdIr = ir; ifIdNpc = npc; ifIdValid = v; flush = f; halted = h;
    wbWe = we; wbAddr = wa; wbData = wd;
  endtask

  // Directed vectors: one row per clk2 cycle.
  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
    logic        v, f, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        expStall, expValid;
    logic [2:0]  expType;
    logic        expHalt, chk;
    logic [31:0] expA, expB, expImm;
  } vec_t;
  vec_t vq[$];

  function automatic void addVec(logic [31:0] ir, logic v, logic f, logic we, logic [4:0] wa,
                                 logic [31:0] wd, logic expStall, logic expValid, logic [2:0] expType,
                                 logic expHalt, logic chk, logic [31:0] expA, logic [31:0] expB,
                                 logic [31:0] expImm);
    vec_t t;
    t.ir = ir; t.npc = 32'h1000 + 32'(vq.size()); t.v = v; t.f = f; t.we = we; t.wa = wa; t.wd = wd;
    t.expStall = expStall; t.expValid = expValid; t.expType = expType; t.expHalt = expHalt;
    t.chk = chk; t.expA = expA; t.expB = expB; t.expImm = expImm;
    vq.push_back(t);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mRegs [32];
  logic        mValid, mHalt;
  logic [2:0]  mType;
  logic [31:0] mIr, mNpc, mA, mB, mImm;

  function automatic logic [2:0] classOf(input logic [5:0] op);
    case (op)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: return T_RR;
      6'd10, 6'd11, 6'd12:                return T_RM;
      6'd8:                               return T_LD;
      6'd9:                               return T_ST;
      6'd13, 6'd14:                       return T_BR;
      6'd63:                              return T_HT;
      default:                            return T_NOP;
    endcase
  endfunction

  function automatic logic [31:0] readReg(input int idx);
    if (idx == 0) return 32'd0;
    if (wbWe && int'(wbAddr) == idx) return wbData;
    return mRegs[idx];
  endfunction

  function automatic logic modelStall();
    logic [2:0] t;
    int rs, rt, dest;
    t = classOf(ifIdIr[31:26]);
    rs = int'(ifIdIr[25:21]); rt = int'(ifIdIr[20:16]); dest = int'(mIr[20:16]);
    if (!mValid || mType != T_LD || dest == 0 || !ifIdValid || flush || halted) return 1'b0;
    return ((t != T_HT && t != T_NOP) && dest == rs) || ((t == T_RR || t == T_ST) && dest == rt);
  endfunction

  // Apply one clk2 edge to the model using the current inputs.
  task automatic modelEdge();
    logic [31:0] a, b;
    logic [2:0]  t;
    logic        st;
    int          iv;
    if (halted) return;
    a = readReg(int'(ifIdIr[25:21]));
    b = readReg(int'(ifIdIr[20:16]));
    st = modelStall();
    t = classOf(ifIdIr[31:26]);
    if (wbWe && wbAddr != 5'd0) mRegs[wbAddr] = wbData;
    if (flush || st || mHalt || !ifIdValid) begin
      mValid = 1'b0; mType = T_NOP;
    end else begin
      iv = int'(ifIdIr[15:0]);
      if (iv >= 32768) iv = iv - 65536;
      mIr = ifIdIr; mNpc = ifIdNpc; mA = a; mB = b; mImm = 32'(iv);
      mType = t; mValid = (t != T_NOP);
      if (t == T_HT) mHalt = 1'b1;
    end
  endtask

  task automatic modelReset();
    mValid = 1'b0; mHalt = 1'b0; mType = T_NOP;
    mIr = '0; mNpc = '0; mA = '0; mB = '0; mImm = '0;
  endtask

  function automatic logic [31:0] randIr();
    logic [5:0] ops [15];
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd7, 6'd20};
    return {ops[$urandom_range(0, 14)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            16'($urandom)};
  endfunction

  initial begin
    logic [31:0] curIr, curNpc;
    logic        curV, holdIf;

    // R3=7, R6=0x66, R1=0x100, R2=0x22, then a discarded write to R0.
    addVec(32'h0, 0, 0, 1, 5'd3, 32'h7,        0, 0, T_NOP, 0, 0, 0, 0, 0);
    addVec(32'h0, 0, 0, 1, 5'd6, 32'h66,       0, 0, T_NOP, 0, 0, 0, 0, 0);
    addVec(32'h0, 0, 0, 1, 5'd1, 32'h100,      0, 0, T_NOP, 0, 0, 0, 0, 0);
    addVec(32'h0, 0, 0, 1, 5'd2, 32'h22,       0, 0, T_NOP, 0, 0, 0, 0, 0);
    addVec(32'h0, 0, 0, 1, 5'd0, 32'h1234,     0, 0, T_NOP, 0, 0, 0, 0, 0);
    // ADD R5,R3,R0
    addVec(32'h00602800, 1, 0, 0, 5'd0, 0,     0, 1, T_RR, 0, 1, 32'h7, 32'h0, 32'h2800);
    // SUBI R6,R4,#-2 with R4 written in the same cycle
    addVec(32'h2C86FFFE, 1, 0, 1, 5'd4, 32'hDEADBEEF, 0, 1, T_RM, 0, 1, 32'hDEADBEEF, 32'h66, 32'hFFFFFFFE);
    // LW R2,0(R1)
    addVec(32'h20220000, 1, 0, 0, 5'd0, 0,     0, 1, T_LD, 0, 1, 32'h100, 32'h22, 32'h0);
    // ADD R7,R2,R2: stall one cycle, then issue
    addVec(32'h00423800, 1, 0, 0, 5'd0, 0,     1, 0, T_NOP, 0, 0, 0, 0, 0);
    addVec(32'h00423800, 1, 0, 0, 5'd0, 0,     0, 1, T_RR, 0, 1, 32'h22, 32'h22, 32'h3800);
    // LW R0,4(R1) then ADD R8,R0,R0: no stall
    addVec(32'h20200004, 1, 0, 0, 5'd0, 0,     0, 1, T_LD, 0, 1, 32'h100, 32'h0, 32'h4);
    addVec(32'h00004000, 1, 0, 0, 5'd0, 0,     0, 1, T_RR, 0, 1, 32'h0, 32'h0, 32'h4000);
    // Unknown opcode
    addVec(32'h3C000000, 1, 0, 0, 5'd0, 0,     0, 0, T_NOP, 0, 0, 0, 0, 0);
    // BEQZ flushed
    addVec(32'h38600005, 1, 1, 0, 5'd0, 0,     0, 0, T_NOP, 0, 0, 0, 0, 0);
    // BNEQZ R3,-1
    addVec(32'h3460FFFF, 1, 0, 0, 5'd0, 0,     0, 1, T_BR, 0, 1, 32'h7, 32'h0, 32'hFFFFFFFF);
    // Flushed HLT does not set halt_seen; real HLT does; later ADD bubbles
    addVec(32'hFC000000, 1, 1, 0, 5'd0, 0,     0, 0, T_NOP, 0, 0, 0, 0, 0);
    addVec(32'hFC000000, 1, 0, 0, 5'd0, 0,     0, 1, T_HT, 1, 1, 32'h0, 32'h0, 32'h0);
    addVec(32'h00602800, 1, 0, 0, 5'd0, 0,     0, 0, T_NOP, 1, 0, 0, 0, 0);

    // ---------------- reset state ----------------
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk2);
    @(negedge clk2);
    checkOutput("rst valid", 32'(idExValid), 0);
    checkOutput("rst type", 32'(idExType), 32'(T_NOP));
    checkOutput("rst halt", 32'(haltSeen), 0);
    checkOutput("rst ir", idExIr, 0);
    checkOutput("rst stall", 32'(stall), 0);
    rst = 1'b0;

    // ---------------- directed table ----------------
    foreach (vq[i]) begin
      if (i != 0) @(negedge clk2);
      applyStimulus(vq[i].ir, vq[i].npc, vq[i].v, vq[i].f, 1'b0, vq[i].we, vq[i].wa, vq[i].wd);
      #1;
      checkOutput($sformatf("vec%0d stall", i), 32'(stall), 32'(vq[i].expStall));
      @(posedge clk2); #1;
      checkOutput($sformatf("vec%0d valid", i), 32'(idExValid), 32'(vq[i].expValid));
      checkOutput($sformatf("vec%0d type", i), 32'(idExType), 32'(vq[i].expType));
      checkOutput($sformatf("vec%0d halt", i), 32'(haltSeen), 32'(vq[i].expHalt));
      if (vq[i].chk) begin
        checkOutput($sformatf("vec%0d a", i), idExA, vq[i].expA);
        checkOutput($sformatf("vec%0d b", i), idExB, vq[i].expB);
        checkOutput($sformatf("vec%0d imm", i), idExImm, vq[i].expImm);
        checkOutput($sformatf("vec%0d ir", i), idExIr, vq[i].ir);
        checkOutput($sformatf("vec%0d npc", i), idExNpc, vq[i].npc);
      end
    end

    // ---------------- async reset between edges ----------------
    @(negedge clk2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("arst ir", idExIr, 0);
    checkOutput("arst npc", idExNpc, 0);
    checkOutput("arst a", idExA, 0);
    checkOutput("arst type", 32'(idExType), 32'(T_NOP));
    checkOutput("arst valid", 32'(idExValid), 0);
    checkOutput("arst halt", 32'(haltSeen), 0);
    @(negedge clk2);
    rst = 1'b0;
    applyStimulus(32'h00602800, 32'h2000, 1, 0, 0, 0, 0, 0);
    @(posedge clk2); #1;
    checkOutput("retain a", idExA, 32'h7);
    checkOutput("retain valid", 32'(idExValid), 1);

    // ---------------- reset during a stall ----------------
    @(negedge clk2);
    applyStimulus(32'h20220000, 32'h2001, 1, 0, 0, 0, 0, 0);
    @(negedge clk2);
    applyStimulus(32'h00423800, 32'h2002, 1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("mid stall", 32'(stall), 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid rst stall", 32'(stall), 0);
    checkOutput("mid rst valid", 32'(idExValid), 0);
    @(negedge clk2);
    rst = 1'b0;

    // ---------------- halted freeze ----------------
    applyStimulus(32'h20220000, 32'h3000, 1, 0, 0, 0, 0, 0);
    @(posedge clk2); #1;
    checkOutput("pre-halt type", 32'(idExType), 32'(T_LD));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk2);
      applyStimulus(32'h00423800, 32'h3001 + 32'(k), 1, 0, 1, 1, 5'd1, 32'h999);
      #1;
      checkOutput($sformatf("frz%0d stall", k), 32'(stall), 0);
      @(posedge clk2); #1;
      checkOutput($sformatf("frz%0d valid", k), 32'(idExValid), 1);
      checkOutput($sformatf("frz%0d type", k), 32'(idExType), 32'(T_LD));
      checkOutput($sformatf("frz%0d ir", k), idExIr, 32'h20220000);
      checkOutput($sformatf("frz%0d npc", k), idExNpc, 32'h3000);
      checkOutput($sformatf("frz%0d a", k), idExA, 32'h100);
    end
    @(negedge clk2);
    applyStimulus(32'h00204000, 32'h3010, 1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("post-frz stall", 32'(stall), 0);
    @(posedge clk2); #1;
    checkOutput("post-frz R1", idExA, 32'h100);

    // ---------------- randomized against the model ----------------
    @(negedge clk2);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    @(negedge clk2);
    rst = 1'b0;
    holdIf = 1'b0;
    curIr = '0; curNpc = '0; curV = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk2);
      if (c < 7) begin
        applyStimulus(0, 0, 0, 0, 0, 1, 5'(c + 1), $urandom);
      end else begin
        if (!holdIf) begin
          curIr = randIr(); curNpc = $urandom; curV = ($urandom_range(0, 9) != 0);
        end
        applyStimulus(curIr, curNpc, curV, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end
      #1;
      holdIf = modelStall();
      checkOutput($sformatf("rnd%0d stall", c), 32'(stall), 32'(holdIf));
      modelEdge();
      @(posedge clk2); #1;
      checkOutput($sformatf("rnd%0d valid", c), 32'(idExValid), 32'(mValid));
      checkOutput($sformatf("rnd%0d type", c), 32'(idExType), 32'(mType));
      checkOutput($sformatf("rnd%0d halt", c), 32'(haltSeen), 32'(mHalt));
      if (mValid) begin
        checkOutput($sformatf("rnd%0d ir", c), idExIr, mIr);
        checkOutput($sformatf("rnd%0d npc", c), idExNpc, mNpc);
        checkOutput($sformatf("rnd%0d a", c), idExA, mA);
        checkOutput($sformatf("rnd%0d b", c), idExB, mB);
        checkOutput($sformatf("rnd%0d imm", c), idExImm, mImm);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
